// File: rtl/conv_scheduler.sv
// Sliding-window convolution scheduler: fetches each FILTERDIM x FILTERDIM window from image RAM,
// presents it to an external kernel, and writes results out. Optional ReLU control: CONV_SCHEDULER_RELU_EN.
module conv_scheduler #(
  parameter int BITWIDTH  = 32,
  parameter int IMGWIDTH  = 28,
  parameter int IMGHEIGHT = 28,
  parameter int FILTERDIM = 5
) (
  input  logic                                  Clk,
  input  logic                                  Reset,
  input  logic                                  start,
  input  logic                                  cfg_relu,
  output logic                                  busy,
  output logic                                  done,
  output logic [$clog2(IMGWIDTH*IMGHEIGHT)-1:0] img_addr,
  input  logic signed [BITWIDTH-1:0]            img_rdata,
  output logic signed [BITWIDTH-1:0]            win_data [FILTERDIM*FILTERDIM],
  output logic                                  relu_enable,
  input  logic signed [BITWIDTH-1:0]            kern_result,
  output logic                                  out_valid,
  output logic [$clog2((IMGWIDTH-FILTERDIM+1)*(IMGHEIGHT-FILTERDIM+1))-1:0] out_addr,
  output logic signed [BITWIDTH-1:0]            out_data,
  input  logic                                  out_ready
);

  localparam int OUTW = IMGWIDTH - FILTERDIM + 1;
  localparam int OUTH = IMGHEIGHT - FILTERDIM + 1;
  localparam int NW   = FILTERDIM * FILTERDIM;
  localparam int AW   = $clog2(IMGWIDTH * IMGHEIGHT);
  localparam int KW   = $clog2(NW + 1);
  localparam int CW   = $clog2(FILTERDIM + 1);
  localparam int RW   = $clog2(OUTH + 1);
  localparam int XW   = $clog2(OUTW + 1);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, CALC, WRITE, DONE} state_t;

  state_t         state, state_n;
  logic [RW-1:0]  row;
  logic [XW-1:0]  col;
  logic [AW-1:0]  win_base;
  logic [KW-1:0]  kcnt;
  logic [KW-1:0]  widx;
  logic [CW-1:0]  kc;
  logic           last_win;
  logic           last_read;
  logic           hs;

  assign last_win  = (row == RW'(OUTH - 1)) && (col == XW'(OUTW - 1));
  assign last_read = (kcnt == KW'(NW - 1));
  assign hs        = out_valid && out_ready;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:  if (start) state_n = FETCH;
      FETCH: begin
        busy = 1'b1;
        if (last_read) state_n = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        state_n = CALC;
      end
      CALC: begin
        busy    = 1'b1;
        state_n = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_n = last_win ? DONE : FETCH;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // img_addr walks the window with counters only: +1 along a line, +(IMGWIDTH-FILTERDIM+1)
  // to the next line; after the last read it holds so the bus stays quiet until the next window.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      row      <= '0;
      col      <= '0;
      win_base <= '0;
      img_addr <= '0;
      out_addr <= '0;
      out_data <= '0;
      kcnt     <= '0;
      widx     <= '0;
      kc       <= '0;
      for (int unsigned i = 0; i < NW; i++) win_data[i] <= '0;
    end else begin
      if (state == IDLE && start) begin
        row      <= '0;
        col      <= '0;
        win_base <= '0;
        img_addr <= '0;
        out_addr <= '0;
        kcnt     <= '0;
        kc       <= '0;
      end

      if (state == FETCH) begin
        widx <= kcnt;
        if (!last_read) begin
          kcnt <= kcnt + KW'(1);
          if (kc == CW'(FILTERDIM - 1)) begin
            kc       <= '0;
            img_addr <= img_addr + AW'(IMGWIDTH - FILTERDIM + 1);
          end else begin
            kc       <= kc + CW'(1);
            img_addr <= img_addr + AW'(1);
          end
        end
      end

      // RAM data lags the address by one cycle, so capture trails issue by one slot.
      if ((state == FETCH && kcnt != '0) || state == DRAIN)
        win_data[widx] <= img_rdata;

      if (state == CALC)
        out_data <= kern_result;

      if (hs) begin
        out_addr <= out_addr + 1'b1;
        kcnt     <= '0;
        kc       <= '0;
        if (col == XW'(OUTW - 1)) begin
          col      <= '0;
          row      <= row + RW'(1);
          win_base <= win_base + AW'(FILTERDIM);
          img_addr <= win_base + AW'(FILTERDIM);
        end else begin
          col      <= col + XW'(1);
          win_base <= win_base + AW'(1);
          img_addr <= win_base + AW'(1);
        end
      end
    end
  end

`ifdef CONV_SCHEDULER_RELU_EN
  logic relu_q;

  always_ff @(posedge Clk) begin
    if (Reset)                     relu_q <= 1'b0;
    else if (state == IDLE && start) relu_q <= cfg_relu;
  end

  assign relu_enable = busy & relu_q;
`else
  logic unused_cfg_relu;

  assign unused_cfg_relu = cfg_relu;
  assign relu_enable     = 1'b0;
`endif

endmodule

// File: tb/tb_conv_scheduler.sv
// Directed bench for conv_scheduler: pixel(i)=i image RAM, all-ones/zero-bias kernel model.
module tb_conv_scheduler;

  localparam int BW   = 32;
  localparam int IW   = 28;
  localparam int IH   = 28;
  localparam int FD   = 5;
  localparam int OUTW = IW - FD + 1;
  localparam int OUTH = IH - FD + 1;
  localparam int NW   = FD * FD;
  localparam int NWIN = OUTW * OUTH;
  localparam int LAST_CYC = NWIN * 28;
`ifdef CONV_SCHEDULER_RELU_EN
  localparam bit RELU_ON = 1'b1;
`else
  localparam bit RELU_ON = 1'b0;
`endif

  logic                 Clk;
  logic                 Reset;
  logic                 start;
  logic                 cfg_relu;
  logic                 busy;
  logic                 done;
  logic [9:0]           img_addr;
  logic signed [BW-1:0] img_rdata;
  logic signed [BW-1:0] win_data [NW];
  logic                 relu_enable;
  logic signed [BW-1:0] kern_result;
  logic                 out_valid;
  logic [9:0]           out_addr;
  logic signed [BW-1:0] out_data;
  logic                 out_ready;
  logic signed [BW-1:0] acc;

  int checks = 0;
  int failures = 0;

  conv_scheduler #(
    .BITWIDTH (BW),
    .IMGWIDTH (IW),
    .IMGHEIGHT(IH),
    .FILTERDIM(FD)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .cfg_relu   (cfg_relu),
    .busy       (busy),
    .done       (done),
    .img_addr   (img_addr),
    .img_rdata  (img_rdata),
    .win_data   (win_data),
    .relu_enable(relu_enable),
    .kern_result(kern_result),
    .out_valid  (out_valid),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .out_ready  (out_ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) img_rdata <= 32'(img_addr);

  always_comb begin
    acc = '0;
    for (int i = 0; i < NW; i++) acc = acc + win_data[i];
    kern_result = acc;
  end

  function automatic int exp_addr(input int w, input int k);
    int r;
    int c;
    r = w / OUTW;
    c = w % OUTW;
    return (r + k / FD) * IW + c + k % FD;
  endfunction

  function automatic int exp_sum(input int w);
    int s;
    s = 0;
    for (int k = 0; k < NW; k++) s += exp_addr(w, k);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    int nz;
    nz = 0;
    for (int k = 0; k < NW; k++) if (win_data[k] !== '0) nz++;
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_img_addr"}, img_addr, 0);
    chk({tag, "_out_addr"}, out_addr, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_relu"}, relu_enable, 0);
    chk({tag, "_win_nonzero"}, nz, 0);
  endtask

  initial begin
    int cyc;
    int w;
    int ph;
    int hs;
    int first_valid;
    int done_cnt;
    int done_cyc;
    bit exp_busy;
    logic [9:0] held_addr;

    Reset = 1'b1;
    start = 1'b0;
    cfg_relu = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk_reset("init");
    Reset = 1'b0;

    // Frame A: uninterrupted frame, starts while busy and in DONE must be ignored.
    @(negedge Clk);
    start = 1'b1;
    cfg_relu = 1'b1;
    cyc = 0;
    hs = 0;
    first_valid = -1;
    done_cnt = 0;
    done_cyc = -1;
    for (int n = 0; n < LAST_CYC + 12; n++) begin
      @(posedge Clk);
      cyc++;
      @(negedge Clk);
      start = (cyc == 100) || (cyc == LAST_CYC + 1);
      cfg_relu = 1'b0;
      w = (cyc - 1) / 28;
      ph = (cyc - 1) % 28;
      exp_busy = (cyc >= 1) && (cyc <= LAST_CYC);
      chk("A_busy", busy, exp_busy);
      chk("A_done", done, cyc == LAST_CYC + 1);
      chk("A_out_valid", out_valid, exp_busy && ph == 27);
      if (exp_busy && ph < NW) chk("A_img_addr", img_addr, exp_addr(w, ph));
      if (exp_busy && ph == 26)
        for (int k = 0; k < NW; k++) chk("A_win_data", win_data[k], exp_addr(w, k));
      if (busy) chk("A_relu", relu_enable, RELU_ON);
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        chk("A_out_addr", out_addr, hs);
        chk("A_out_data", out_data, exp_sum(hs));
        hs++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    chk("A_first_valid_cycle", first_valid, 28);
    chk("A_handshakes", hs, NWIN);
    chk("A_done_count", done_cnt, 1);
    chk("A_done_cycle", done_cyc, LAST_CYC + 1);
    chk("A_first_data", exp_sum(0), 1450);
    chk("A_last_data", exp_sum(NWIN - 1), 18125);

    // Frame B: 10-cycle stall on window 3, then reset (with start) during window 100 fetch.
    @(negedge Clk);
    start = 1'b1;
    cfg_relu = 1'b0;
    cyc = 0;
    held_addr = '0;
    for (int n = 0; n < 2815; n++) begin
      @(posedge Clk);
      cyc++;
      @(negedge Clk);
      start = 1'b0;
      out_ready = !(cyc >= 112 && cyc <= 121);
      if (busy) chk("B_relu", relu_enable, 0);
      if (cyc == 112) held_addr = img_addr;
      if (cyc >= 112 && cyc <= 122) begin
        chk("B_stall_valid", out_valid, 1);
        chk("B_stall_out_addr", out_addr, 3);
        chk("B_stall_out_data", out_data, exp_sum(3));
        if (cyc > 112) chk("B_stall_img_addr", img_addr, held_addr);
        for (int k = 0; k < NW; k++) chk("B_stall_win", win_data[k], exp_addr(3, k));
      end
      if (cyc == 123) begin
        chk("B_w4_busy", busy, 1);
        chk("B_w4_valid", out_valid, 0);
        chk("B_w4_img_addr", img_addr, exp_addr(4, 0));
      end
      if (cyc == 124) chk("B_w4_img_addr1", img_addr, exp_addr(4, 1));
      if (cyc == 150) begin
        chk("B_w4_out_valid", out_valid, 1);
        chk("B_w4_out_addr", out_addr, 4);
        chk("B_w4_out_data", out_data, exp_sum(4));
      end
      if (cyc == 2813) begin
        chk("B_w100_busy", busy, 1);
        chk("B_w100_img_addr", img_addr, exp_addr(100, 2));
      end
    end
    Reset = 1'b1;
    start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    chk_reset("B_rst");
    Reset = 1'b0;
    start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge Clk);
      @(negedge Clk);
      chk("B_idle_busy", busy, 0);
      chk("B_idle_valid", out_valid, 0);
    end

    // Frame C: fresh start after the abandoned frame begins at window 0.
    start = 1'b1;
    cyc = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge Clk);
      cyc++;
      @(negedge Clk);
      start = 1'b0;
      if (cyc == 1) begin
        chk("C_busy", busy, 1);
        chk("C_img_addr", img_addr, 0);
      end
      if (cyc == 27) chk("C_valid_early", out_valid, 0);
      if (cyc == 28) begin
        chk("C_out_valid", out_valid, 1);
        chk("C_out_addr", out_addr, 0);
        chk("C_out_data", out_data, exp_sum(0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
